// File: rtl/uart_menu_client_pkg.sv
// Shared constants and FSM state type for the UART menu client.
package uart_pkg;

    localparam int unsigned OSR        = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = DATA_BITS + 2;
    localparam int unsigned CNT_W      = 10;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LISTEN,
        RECV
    } state_t;

endpackage

// File: rtl/uart_menu_client_rsp_fifo.sv
// Reply byte FIFO: power-of-two depth, combinational head, push allowed when full if popping.
module rsp_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)
                count <= count + (AW+1)'(1);
            else if (!push_ok && pop_ok)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_menu_client.sv
// UART command initiator: sends one command byte as 8N1, then collects the reply
// into a FIFO until the line goes idle or no reply arrives in time.
module uart_menu_client
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = 54,
    parameter int unsigned IDLE_BITS     = 20,
    parameter int unsigned RSP_TIMEOUT   = 4096,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_byte,
    output logic             tx,
    input  logic             rx,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_byte,
    output logic [CNT_W-1:0] rsp_count,
    output logic             done,
    output logic             timeout,
    output logic             overflow,
    output logic             frame_err
);

    localparam int unsigned TICK_W  = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int unsigned TO_TICKS   = RSP_TIMEOUT * OSR;
    localparam int unsigned IDLE_TICKS = IDLE_BITS * OSR;
    localparam int unsigned GAP_MAX = (TO_TICKS > IDLE_TICKS) ? TO_TICKS : IDLE_TICKS;
    localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    always_ff @(posedge clk) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TICK_W'(1);
    end

    assign tick = (tick_cnt == TICK_W'(CLKS_PER_TICK - 1));

    // Receiver: always armed; starts only on a falling edge so a low stop bit cannot retrigger.
    logic       rx_meta;
    logic       rx_sync;
    logic       rx_prev;
    logic       rx_busy;
    logic [3:0] rx_phase;
    logic [3:0] rx_bit;
    logic [7:0] rx_shift;
    logic       rx_push;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

    assign fifo_pop  = rsp_ready && !fifo_empty;
    assign rsp_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_busy   <= 1'b0;
            rx_phase  <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_push   <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            rx_push <= 1'b0;
            if (rx_push && fifo_full && !fifo_pop)
                overflow <= 1'b1;
            if (!rx_busy) begin
                if (rx_prev && !rx_sync) begin
                    rx_busy  <= 1'b1;
                    rx_phase <= '0;
                    rx_bit   <= '0;
                end
            end else if (tick) begin
                rx_phase <= rx_phase + 4'd1;
                if (rx_phase == 4'(OSR / 2 - 1)) begin
                    rx_bit <= rx_bit + 4'd1;
                    if (rx_bit == 4'd0) begin
                        if (rx_sync) rx_busy <= 1'b0;
                    end else if (rx_bit <= 4'(DATA_BITS)) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                    end else begin
                        rx_busy <= 1'b0;
                        if (rx_sync)
                            rx_push <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end
                end
            end
        end
    end

    rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (rx_shift),
        .pop   (fifo_pop),
        .dout  (rsp_byte),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    state_t           state;
    logic [9:0]       tx_shift;
    logic             tx_active;
    logic [3:0]       tx_phase;
    logic [3:0]       tx_bit;
    logic [GAP_W-1:0] gap;

    // done is raised while still in LISTEN/RECV; the return to IDLE happens the cycle after.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            rsp_count <= '0;
            tx_shift  <= '1;
            tx_active <= 1'b0;
            tx_phase  <= '0;
            tx_bit    <= '0;
            gap       <= '0;
        end else begin
            done <= 1'b0;
            if (rx_push && (state == LISTEN || state == RECV) && !done && rsp_count != '1)
                rsp_count <= rsp_count + CNT_W'(1);
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tx_shift  <= {1'b1, cmd_byte, 1'b0};
                        tx_active <= 1'b0;
                        cmd_ready <= 1'b0;
                        rsp_count <= '0;
                        timeout   <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (tick) begin
                        if (!tx_active) begin
                            tx_active <= 1'b1;
                            tx        <= tx_shift[0];
                            tx_shift  <= {1'b1, tx_shift[9:1]};
                            tx_phase  <= '0;
                            tx_bit    <= '0;
                        end else if (tx_phase == 4'(OSR - 1)) begin
                            tx_phase <= '0;
                            if (tx_bit == 4'(FRAME_BITS - 1)) begin
                                tx_active <= 1'b0;
                                gap       <= '0;
                                state     <= LISTEN;
                            end else begin
                                tx       <= tx_shift[0];
                                tx_shift <= {1'b1, tx_shift[9:1]};
                                tx_bit   <= tx_bit + 4'd1;
                            end
                        end else begin
                            tx_phase <= tx_phase + 4'd1;
                        end
                    end
                end
                LISTEN: begin
                    if (done) begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (rx_push) begin
                        gap   <= '0;
                        state <= RECV;
                    end else if (tick) begin
                        if (gap == GAP_W'(TO_TICKS - 1)) begin
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end else begin
                            gap <= gap + GAP_W'(1);
                        end
                    end
                end
                RECV: begin
                    if (done) begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (rx_push || !rx_sync) begin
                        gap <= '0;
                    end else if (tick) begin
                        if (gap >= GAP_W'(IDLE_TICKS - 1)) begin
                            if (!rx_busy) done <= 1'b1;
                        end else begin
                            gap <= gap + GAP_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_menu_client.sv
// Randomized self-checking bench for uart_menu_client with a queue-based reply model.
module tb_uart_menu_client;

    localparam int unsigned CPT         = 3;
    localparam int unsigned IDLE_BITS   = 20;
    localparam int unsigned RSP_TIMEOUT = 64;
    localparam int unsigned DEPTH       = 16;
    localparam int          BIT         = CPT * 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       rx = 1'b1;
    logic       rsp_ready = 1'b0;
    logic       cmd_ready;
    logic       tx;
    logic       rsp_valid;
    logic [7:0] rsp_byte;
    logic [9:0] rsp_count;
    logic       done;
    logic       timeout;
    logic       overflow;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_total = 0;
    int done_base = 0;

    logic [7:0] exp_q[$];
    logic       ovf_exp = 1'b0;
    logic       ferr_exp = 1'b0;
    logic       to_exp = 1'b0;
    int         cnt_exp = 0;

    uart_menu_client #(
        .CLKS_PER_TICK (CPT),
        .IDLE_BITS     (IDLE_BITS),
        .RSP_TIMEOUT   (RSP_TIMEOUT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_byte  (cmd_byte),
        .tx        (tx),
        .rx        (rx),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_byte  (rsp_byte),
        .rsp_count (rsp_count),
        .done      (done),
        .timeout   (timeout),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && done === 1'b1) done_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one 8N1 frame on rx and updates the reply model.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic in_txn);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        if (stop_bit) begin
            if (in_txn && cnt_exp < 1023) cnt_exp++;
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else ovf_exp = 1'b1;
        end else begin
            ferr_exp = 1'b1;
        end
    endtask

    // Issues a command and checks the transmitted frame cycle by cycle.
    task automatic issue_cmd(input logic [7:0] c);
        logic [9:0] fr;
        logic [7:0] dec;
        int lat, bad_tx, bad_rdy;
        fr = {1'b1, c, 1'b0};
        dec = 8'h00;
        bad_tx = 0;
        bad_rdy = 0;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_byte = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        done_base = done_total;
        cnt_exp = 0;
        check("cmd_ready_drop", 32'(cmd_ready), 32'd0);
        lat = 0;
        while (tx === 1'b1 && lat < 4 * int'(CPT)) begin
            @(negedge clk);
            lat++;
        end
        check("tx_fall_latency", 32'(lat < 4 * int'(CPT)), 32'd1);
        for (int j = 0; j < 10 * BIT; j++) begin
            if (tx !== fr[j / BIT]) bad_tx++;
            if (cmd_ready !== 1'b0) bad_rdy++;
            if ((j % BIT) == BIT / 2 && j / BIT >= 1 && j / BIT <= 8)
                dec[j / BIT - 1] = tx;
            @(negedge clk);
        end
        check("tx_frame_cycles", 32'(bad_tx), 32'd0);
        check("tx_byte", 32'(dec), 32'(c));
        check("cmd_ready_busy", 32'(bad_rdy), 32'd0);
    endtask

    task automatic wait_done(input int bound, output int lat);
        logic [9:0] cnt_at;
        logic       to_at;
        lat = 0;
        while (done !== 1'b1 && lat < bound) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", 32'(done), 32'd1);
        cnt_at = rsp_count;
        to_at = timeout;
        check("rsp_count", 32'(rsp_count), 32'(cnt_exp));
        check("timeout", 32'(timeout), 32'(to_exp));
        check("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("rsp_count_hold", 32'(rsp_count), 32'(cnt_at));
        check("timeout_hold", 32'(timeout), 32'(to_at));
        check("cmd_ready_after", 32'(cmd_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("done_pulses", 32'(done_total - done_base), 32'd1);
    endtask

    task automatic drain();
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_byte", 32'(rsp_byte), 32'(e));
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        @(negedge clk);
        check("fifo_empty", 32'(rsp_valid), 32'd0);
        check("overflow", 32'(overflow), 32'(ovf_exp));
        check("frame_err", 32'(frame_err), 32'(ferr_exp));
    endtask

    task automatic run_txn(input logic [7:0] c, input int n, input int max_gap_bits, input logic check_gap);
        int lat;
        logic [7:0] b;
        to_exp = (n == 0);
        issue_cmd(c);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(max_gap_bits, 0) * BIT) @(negedge clk);
            b = 8'($urandom);
            send_byte(b, 1'b1, 1'b1);
        end
        if (n == 0) begin
            wait_done(int'(RSP_TIMEOUT) * BIT + 4 * BIT, lat);
            check("timeout_latency", 32'(lat >= int'(RSP_TIMEOUT) * BIT - 4 && lat <= int'(RSP_TIMEOUT) * BIT + 4), 32'd1);
        end else begin
            wait_done(25 * BIT, lat);
            if (check_gap)
                check("idle_gap_latency", 32'(lat >= 19 * BIT && lat <= 21 * BIT), 32'd1);
        end
        drain();
    endtask

    initial begin
        int lat;
        logic [7:0] ab [4];
        ab[0] = 8'h41; ab[1] = 8'h42; ab[2] = 8'h0D; ab[3] = 8'h0A;

        repeat (10) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_count", 32'(rsp_count), 32'd0);
        check("rst_flags", 32'({done, timeout, overflow, frame_err}), 32'd0);
        rst_n = 1'b1;

        // short low glitch must be rejected at the mid-start check
        @(negedge clk);
        rx = 1'b0;
        repeat (5 * CPT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch_no_byte", 32'(rsp_valid), 32'd0);
        check("glitch_no_flag", 32'(frame_err), 32'd0);

        // unsolicited byte in IDLE is buffered but not counted
        send_byte(8'h5A, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("banner_rsp_count", 32'(rsp_count), 32'd0);
        drain();

        // directed command 0x31 with reply "AB\r\n"
        to_exp = 1'b0;
        issue_cmd(8'h31);
        for (int k = 0; k < 4; k++) send_byte(ab[k], 1'b1, 1'b1);
        wait_done(25 * BIT, lat);
        check("ab_gap_latency", 32'(lat >= 19 * BIT && lat <= 21 * BIT), 32'd1);
        drain();

        // silent line: first-byte timeout
        run_txn(8'($urandom), 0, 0, 1'b0);

        // 20 bytes with consumer stalled: 16 kept, overflow sticky
        run_txn(8'h3F, 20, 0, 1'b1);

        // randomized transactions
        for (int t = 0; t < 3; t++)
            run_txn(8'($urandom), int'($urandom_range(18, 0)), 3, 1'b1);

        // bad stop bit in IDLE
        send_byte(8'($urandom), 1'b0, 1'b0);
        repeat (BIT) @(negedge clk);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_no_push", 32'(rsp_valid), 32'd0);

        // reset in the middle of the start bit
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_byte = 8'hC3;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (tx === 1'b1 && lat < 4 * int'(CPT)) begin
            @(negedge clk);
            lat++;
        end
        repeat (BIT / 2) @(negedge clk);
        check("tx_low_pre_rst", 32'(tx), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        ovf_exp = 1'b0;
        ferr_exp = 1'b0;
        cnt_exp = 0;
        @(negedge clk);
        check("rst_mid_flags", 32'({overflow, frame_err, timeout, done}), 32'd0);
        check("rst_mid_count", 32'(rsp_count), 32'(cnt_exp));
        check("rst_mid_empty", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
